altera_syncram_multistage_fwd: RTL and testbench
================================================

# altera_syncram_multistage_fwd

Parametrised read-during-write forwarding pipeline for simulation models of simple dual-port syncram with configurable read latency, write-commit latency and byte enables. It sits beside the RAM array and tracks every in-flight read and every not-yet-committed write. Per byte lane, it substitutes the youngest uncommitted write data into the raw RAM output, giving "new data" read-during-write semantics over a multi-cycle window.

## Interface
Parameters:
- DWIDTH, 32, data width; must equal BEWIDTH*8.
- AWIDTH, 8, address width.
- BEWIDTH, 4, byte-enable width.
- RD_LATENCY, 2, cycles from rden to ram_q valid; legal range 1..4.
- WR_LATENCY, 2, cycles from wren until the write is visible to a newly issued read; legal range 1..4.
- FWD_ENABLE, 1, 1 = forward; 0 = pass ram_q through unchanged (old-data mode).

Ports:
- clock  in  1  single clock; all state on posedge.
- aclr  in  1  asynchronous, active-high reset.
- wren  in  1  write strobe.
- wraddr  in  AWIDTH  write address.
- wrdata  in  DWIDTH  write data.
- byteena  in  BEWIDTH  per-byte write enable.
- rden  in  1  read strobe.
- rdaddr  in  AWIDTH  read address.
- ram_q  in  DWIDTH  raw RAM output, valid RD_LATENCY cycles after rden.
- q  out  DWIDTH  corrected read data.
- q_valid  out  1  q corresponds to a tracked read.
- fwd_hit  out  1  at least one byte of q was substituted.

## Operation
- RAM model contract: a read issued at cycle t returns (via ram_q) data reflecting only writes issued at cycles ≤ t−WR_LATENCY.
- The block must supply writes issued in cycles t−WR_LATENCY+1 .. t.
- Write history: shift register of WR_LATENCY−1 entries {valid, addr, data, be}.
  - Shifts every cycle.
  - Entry 0 loads {wren && |byteena, wraddr, wrdata, byteena}.
  - The oldest entry is discarded.
  - For WR_LATENCY=1 the history is empty; only the current-cycle write is considered.
- Merge at read issue (cycle t, rden=1):
  - Candidates are the current-cycle write plus every valid history entry with addr == rdaddr.
  - Per byte, the youngest candidate with that byte enabled supplies the byte and sets mask bit.
  - Current cycle is youngest.
- Read pipeline: RD_LATENCY stages of {valid, mask[BEWIDTH], fdata[DWIDTH]}. Stage 0 loads {rden, merged mask, merged data}.
- Output, combinational from the last stage:
  - q byte i = mask[i] ? fdata byte i : ram_q byte i.
  - q_valid = last.valid.
  - fwd_hit = last.valid && |mask.
- Writes issued after the read cycle are never merged into that read.
- wren with byteena=0 is a no-op: it enters history invalid.
- rden=0: stage 0 loads valid=0 and mask=0.
- FWD_ENABLE=0: mask is forced to 0 everywhere, so q=ram_q and fwd_hit=0. q_valid still tracks reads.
- Simultaneous read and write to the same address in the same cycle: forwarded (the current write is the youngest candidate).
- Address wrap: none; compares are exact AWIDTH equality.

## Timing
- Reset (aclr=1, asynchronous):
  - Clears all history valid/be/data and all pipeline valid/mask/fdata to 0.
  - Outputs immediately: q_valid=0, fwd_hit=0, q=ram_q.
- Reset mid-operation: all in-flight reads are dropped; no q_valid pulse for reads issued before deassertion.
  - First tracked read is one issued on the first posedge with aclr=0.
- Latency: a read at posedge t produces q_valid=1 during cycle t+RD_LATENCY, aligned with ram_q.
- Throughput: one read and one write per cycle, no stalls, no backpressure.
- Merge logic is combinational into stage 0. The only combinational output path is ram_q → q.

## Test plan
Configuration for all scenarios: DWIDTH=32, BEWIDTH=4, RD_LATENCY=2, WR_LATENCY=2.
- Same-cycle hit: cycle 10 write addr 5, data 0x11223344, be=F, plus read addr 5; ram_q=0xDEADBEEF at cycle 12 → q=0x11223344, q_valid=1, fwd_hit=1 at 12.
- Window edge:
  - Write addr 5 data 0xAAAAAAAA be=F at cycle 9, read at cycle 10 → q=0xAAAAAAAA.
  - Same write at cycle 8 → q=ram_q, fwd_hit=0.
- Byte merge: cycle 9 write addr 7 be=0001 data 0x000000AB; cycle 10 write addr 7 be=0100 data 0x00CD0000 plus read addr 7; ram_q=0x11111111 → q=0x11CD11AB.
- Youngest wins: cycle 9 be=F 0x11111111; cycle 10 be=0011 0x22222222 plus read; ram_q=0 → q=0x11112222.
- Reset mid-flight: read at cycle 10, aclr pulsed during cycle 11 → q_valid=0, fwd_hit=0 at 12, q=ram_q. A read at the first clean posedge yields q_valid 2 cycles later.
- FWD_ENABLE=0 repeat of the same-cycle-hit scenario → q=0xDEADBEEF, fwd_hit=0, q_valid=1.

Source files
------------

// File: rtl/altera_syncram_multistage_fwd.sv
// Read-during-write forwarding beside a simple dual-port syncram model: tracks in-flight
// reads and uncommitted writes, substituting the youngest pending write bytes into ram_q.
module altera_syncram_multistage_fwd #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 8,
    parameter int BEWIDTH    = 4,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 2,
    parameter int FWD_ENABLE = 1
) (
    input  logic               clock,
    input  logic               aclr,
    input  logic               wren,
    input  logic [AWIDTH-1:0]  wraddr,
    input  logic [DWIDTH-1:0]  wrdata,
    input  logic [BEWIDTH-1:0] byteena,
    input  logic               rden,
    input  logic [AWIDTH-1:0]  rdaddr,
    input  logic [DWIDTH-1:0]  ram_q,
    output logic [DWIDTH-1:0]  q,
    output logic               q_valid,
    output logic               fwd_hit
);

    // WR_LATENCY=1 keeps a single dummy entry that is never loaded nor consulted
    localparam int unsigned HDEPTH = (WR_LATENCY > 1) ? WR_LATENCY - 1 : 1;
    localparam int unsigned LAST   = RD_LATENCY - 1;

    logic [HDEPTH-1:0]                 h_valid;
    logic [HDEPTH-1:0][AWIDTH-1:0]     h_addr;
    logic [HDEPTH-1:0][DWIDTH-1:0]     h_data;
    logic [HDEPTH-1:0][BEWIDTH-1:0]    h_be;

    logic [RD_LATENCY-1:0]              p_valid;
    logic [RD_LATENCY-1:0][BEWIDTH-1:0] p_mask;
    logic [RD_LATENCY-1:0][DWIDTH-1:0]  p_data;

    logic [BEWIDTH-1:0] m_mask;
    logic [DWIDTH-1:0]  m_data;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            h_valid <= '0;
            h_addr  <= '0;
            h_data  <= '0;
            h_be    <= '0;
        end else if (WR_LATENCY > 1) begin
            h_valid[0] <= wren && (|byteena);
            h_addr[0]  <= wraddr;
            h_data[0]  <= wrdata;
            h_be[0]    <= byteena;
            for (int unsigned i = 1; i < HDEPTH; i++) begin
                h_valid[i] <= h_valid[i-1];
                h_addr[i]  <= h_addr[i-1];
                h_data[i]  <= h_data[i-1];
                h_be[i]    <= h_be[i-1];
            end
        end
    end

    // Oldest candidates are applied first so younger writes overwrite their bytes.
    always_comb begin
        m_mask = '0;
        m_data = '0;
        if (FWD_ENABLE != 0) begin
            if (WR_LATENCY > 1) begin
                for (int unsigned k = HDEPTH; k > 0; k--) begin
                    if (h_valid[k-1] && (h_addr[k-1] == rdaddr)) begin
                        for (int unsigned b = 0; b < BEWIDTH; b++) begin
                            if (h_be[k-1][b]) begin
                                m_mask[b]         = 1'b1;
                                m_data[b*8 +: 8]  = h_data[k-1][b*8 +: 8];
                            end
                        end
                    end
                end
            end
            if (wren && (wraddr == rdaddr)) begin
                for (int unsigned b = 0; b < BEWIDTH; b++) begin
                    if (byteena[b]) begin
                        m_mask[b]        = 1'b1;
                        m_data[b*8 +: 8] = wrdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            p_valid <= '0;
            p_mask  <= '0;
            p_data  <= '0;
        end else begin
            p_valid[0] <= rden;
            p_mask[0]  <= rden ? m_mask : '0;
            p_data[0]  <= rden ? m_data : '0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_mask[i]  <= p_mask[i-1];
                p_data[i]  <= p_data[i-1];
            end
        end
    end

    always_comb begin
        q = ram_q;
        for (int unsigned b = 0; b < BEWIDTH; b++) begin
            if (p_mask[LAST][b]) q[b*8 +: 8] = p_data[LAST][b*8 +: 8];
        end
        q_valid = p_valid[LAST];
        fwd_hit = p_valid[LAST] && (|p_mask[LAST]);
    end

endmodule

// File: tb/tb_altera_syncram_multistage_fwd.sv
// Scoreboard bench: forwarding and old-data instances share stimulus; expectations are
// queued at read issue and compared when each read reaches the output.
module tb_altera_syncram_multistage_fwd;

    logic        clock = 1'b0;
    logic        aclr;
    logic        wren;
    logic [7:0]  wraddr;
    logic [31:0] wrdata;
    logic [3:0]  byteena;
    logic        rden;
    logic [7:0]  rdaddr;
    logic [31:0] ram_q;
    logic [31:0] q_f, q_o;
    logic        qv_f, qv_o, hit_f, hit_o;

    always #5 clock = ~clock;

    altera_syncram_multistage_fwd #(.DWIDTH(32), .AWIDTH(8), .BEWIDTH(4),
        .RD_LATENCY(2), .WR_LATENCY(2), .FWD_ENABLE(1)) u_fwd (
        .clock(clock), .aclr(aclr), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .byteena(byteena), .rden(rden), .rdaddr(rdaddr), .ram_q(ram_q),
        .q(q_f), .q_valid(qv_f), .fwd_hit(hit_f));

    altera_syncram_multistage_fwd #(.DWIDTH(32), .AWIDTH(8), .BEWIDTH(4),
        .RD_LATENCY(2), .WR_LATENCY(2), .FWD_ENABLE(0)) u_old (
        .clock(clock), .aclr(aclr), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .byteena(byteena), .rden(rden), .rdaddr(rdaddr), .ram_q(ram_q),
        .q(q_o), .q_valid(qv_o), .fwd_hit(hit_o));

    typedef struct {
        int          due;
        logic [31:0] ramq;
        logic [31:0] q;
        logic        hit;
    } sb_t;

    sb_t sbq[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    // Advance one cycle, clear strobes, drive ram_q and compare outputs against the scoreboard.
    task automatic tick();
        sb_t e;
        @(posedge clock);
        #1;
        cyc++;
        wren = 1'b0; rden = 1'b0; byteena = '0;
        wraddr = '0; wrdata = '0; rdaddr = '0;
        if (sbq.size() > 0 && sbq[0].due == cyc) ram_q = sbq[0].ramq;
        else ram_q = $urandom;
        @(negedge clock);
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            total++;
            if ({qv_f, hit_f, q_f} !== {1'b1, e.hit, e.q}) begin
                bad++;
                $display("FAIL read_fwd cyc=%0d got v=%b hit=%b q=%h want v=1 hit=%b q=%h",
                         cyc, qv_f, hit_f, q_f, e.hit, e.q);
            end
            total++;
            if ({qv_o, hit_o, q_o} !== {1'b1, 1'b0, e.ramq}) begin
                bad++;
                $display("FAIL read_old cyc=%0d got v=%b hit=%b q=%h want v=1 hit=0 q=%h",
                         cyc, qv_o, hit_o, q_o, e.ramq);
            end
        end else begin
            total++;
            if ({qv_f, hit_f, q_f, qv_o, hit_o, q_o} !== {2'b00, ram_q, 2'b00, ram_q}) begin
                bad++;
                $display("FAIL idle cyc=%0d got fv=%b fh=%b fq=%h ov=%b oh=%b oq=%h want v=0 hit=0 q=%h",
                         cyc, qv_f, hit_f, q_f, qv_o, hit_o, q_o, ram_q);
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wren = 1'b1; wraddr = a; wrdata = d; byteena = be;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] rq,
                           input logic [31:0] eq, input logic eh);
        sb_t e;
        rden = 1'b1; rdaddr = a;
        e.due = cyc + 2; e.ramq = rq; e.q = eq; e.hit = eh;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        repeat (3) tick();
        ram_q = 32'h5A5A_1234;
        #1;
        total++;
        if ({qv_f, hit_f, q_f} !== {2'b00, 32'h5A5A_1234}) begin
            bad++;
            $display("FAIL reset_out got v=%b hit=%b q=%h want v=0 hit=0 q=5a5a1234", qv_f, hit_f, q_f);
        end
        aclr = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle_hit();
        do_write(8'd5, 32'h1122_3344, 4'hF);
        do_read(8'd5, 32'hDEAD_BEEF, 32'h1122_3344, 1'b1);
        repeat (3) tick();
    endtask

    task automatic test_window_edge();
        do_write(8'd5, 32'hAAAA_AAAA, 4'hF);
        tick();
        do_read(8'd5, 32'h1234_5678, 32'hAAAA_AAAA, 1'b1);
        repeat (3) tick();
        do_write(8'd5, 32'hAAAA_AAAA, 4'hF);
        repeat (2) tick();
        do_read(8'd5, 32'h1234_5678, 32'h1234_5678, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_byte_merge();
        do_write(8'd7, 32'h0000_00AB, 4'b0001);
        tick();
        do_write(8'd7, 32'h00CD_0000, 4'b0100);
        do_read(8'd7, 32'h1111_1111, 32'h11CD_11AB, 1'b1);
        repeat (3) tick();
    endtask

    task automatic test_youngest_wins();
        do_write(8'd7, 32'h1111_1111, 4'hF);
        tick();
        do_write(8'd7, 32'h2222_2222, 4'b0011);
        do_read(8'd7, 32'h0000_0000, 32'h1111_2222, 1'b1);
        repeat (3) tick();
    endtask

    task automatic test_noop_and_miss();
        do_write(8'd9, 32'hFFFF_FFFF, 4'h0);
        tick();
        do_write(8'd9, 32'hEEEE_EEEE, 4'h0);
        do_read(8'd9, 32'h5555_5555, 32'h5555_5555, 1'b0);
        repeat (3) tick();
        do_write(8'd10, 32'h7777_7777, 4'hF);
        do_read(8'd11, 32'h3333_3333, 32'h3333_3333, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_mid_reset();
        do_write(8'd5, 32'hCAFE_F00D, 4'hF);
        rden = 1'b1; rdaddr = 8'd5;
        tick();
        aclr = 1'b1;
        #1;
        total++;
        if ({qv_f, hit_f, q_f, qv_o} !== {2'b00, ram_q, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got v=%b hit=%b q=%h ov=%b want v=0 hit=0 q=%h ov=0",
                     qv_f, hit_f, q_f, qv_o, ram_q);
        end
        aclr = 1'b0;
        #1;
        do_read(8'd3, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, prev, r;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            r = $urandom;
            do_write(8'h20 + 8'(i), d, 4'hF);
            if (i > 0) do_read(8'h20 + 8'(i - 1), r, prev, 1'b1);
            else do_read(8'h40, r, r, 1'b0);
            prev = d;
            tick();
        end
        repeat (3) tick();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sbq.size());
        end
    endtask

    initial begin
        wren = 1'b0; wraddr = '0; wrdata = '0; byteena = '0;
        rden = 1'b0; rdaddr = '0; ram_q = '0; aclr = 1'b1;
        test_reset();
        test_same_cycle_hit();
        test_window_edge();
        test_byte_merge();
        test_youngest_wins();
        test_noop_and_miss();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
